// File: rtl/mem_pkg.sv
// Shared types and sizes for the memory arbiter slice.
package mem_pkg;
    localparam int MEM_AW = 4;
    localparam int MEM_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        TURN = 2'd3
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } req_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes and memory control lines of the arbiter.
interface mem_arbiter_if;
    import mem_pkg::*;

    logic              req_a, req_b;
    logic              we_a, we_b;
    logic [MEM_AW-1:0] addr_a, addr_b;
    logic [MEM_DW-1:0] wdata_a, wdata_b;
    logic              gnt_a, gnt_b;
    logic              done_a, done_b;
    logic [MEM_DW-1:0] rdata;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re, mem_we;

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        output gnt_a, gnt_b, done_a, done_b, rdata, mem_addr, mem_re, mem_we
    );

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        input  gnt_a, gnt_b, done_a, done_b, rdata, mem_addr, mem_re, mem_we
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_arb2
    import mem_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  owner_t last_grant,
    output owner_t winner,
    output logic   valid
);
    assign valid = req_a | req_b;

    always_comb begin
        winner = OWN_A;
        if (req_a && req_b) winner = (last_grant == OWN_A) ? OWN_B : OWN_A;
        else if (req_b)     winner = OWN_B;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for a 16x8 single-port memory with a shared
// bidirectional data bus; all outputs come from registered state.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int RD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.slave      bus,
    inout  wire  [MEM_DW-1:0] data_bus
);
    localparam int CNT_W = 2;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_grant_q, last_grant_d;
    owner_t            winner;
    logic              pick_vld;
    req_t              req_sel;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [MEM_DW-1:0] wdata_q, wdata_d;
    logic [MEM_DW-1:0] rdata_q, rdata_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic              done_a_q, done_a_d, done_b_q, done_b_d;

    rr_arb2 u_rr (
        .req_a      (bus.req_a),
        .req_b      (bus.req_b),
        .last_grant (last_grant_q),
        .winner     (winner),
        .valid      (pick_vld)
    );

    always_comb begin
        if (winner == OWN_B) req_sel = '{we: bus.we_b, addr: bus.addr_b, wdata: bus.wdata_b};
        else                 req_sel = '{we: bus.we_a, addr: bus.addr_a, wdata: bus.wdata_a};
    end

    // Next-state values are the outputs for the coming cycle, so gnt/mem_* line up
    // with the WR/RD state they belong to.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rd_cnt_d     = rd_cnt_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        gnt_a_d      = 1'b0;
        gnt_b_d      = 1'b0;
        done_a_d     = 1'b0;
        done_b_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d    = winner;
                    mem_addr_d = req_sel.addr;
                    wdata_d    = req_sel.wdata;
                    rd_cnt_d   = '0;
                    gnt_a_d    = (winner == OWN_A);
                    gnt_b_d    = (winner == OWN_B);
                    if (req_sel.we) begin
                        state_d  = WR;
                        mem_we_d = 1'b1;
                    end else begin
                        state_d  = RD;
                        mem_re_d = 1'b1;
                    end
                end
            end
            WR: begin
                state_d  = TURN;
                done_a_d = (owner_q == OWN_A);
                done_b_d = (owner_q == OWN_B);
            end
            RD: begin
                if (rd_cnt_q == CNT_W'(RD_CYCLES - 1)) begin
                    rdata_d  = data_bus;
                    state_d  = TURN;
                    done_a_d = (owner_q == OWN_A);
                    done_b_d = (owner_q == OWN_B);
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    mem_re_d = 1'b1;
                end
            end
            TURN: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_A;
            last_grant_q <= OWN_B;
            rd_cnt_q     <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            done_a_q     <= 1'b0;
            done_b_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rd_cnt_q     <= rd_cnt_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            done_a_q     <= done_a_d;
            done_b_q     <= done_b_d;
        end
    end

    // Released as soon as reset knocks state_q out of WR, no clock needed.
    assign data_bus = (state_q == WR) ? wdata_q : 'z;

    assign bus.gnt_a    = gnt_a_q;
    assign bus.gnt_b    = gnt_b_q;
    assign bus.done_a   = done_a_q;
    assign bus.done_b   = done_b_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_re   = mem_re_q;
    assign bus.mem_we   = mem_we_q;
endmodule
